// File: rtl/usb_tx_sched.sv
// usb_tx_sched: sequencer/arbiter in front of the USB TX packet engine.
//
// Two requesters share the engine:
//   HS - PID-only handshake packets (ACK/NAK/STALL), fixed highest priority.
//   DT - DATA0/DATA1 packets whose payload is streamed from an endpoint buffer.
// After each packet a minimum inter-packet gap is enforced, and a watchdog
// abandons a packet the engine never completes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   tx_en               grants allowed only while high
//   hs_req/hs_pid       HS request (level) and PID; hs_done pulses on completion
//   dt_req/dt_pid/      DT request (level), PID, payload length and current byte;
//   dt_len/dt_data      dt_data_ack asks for the next byte; dt_done pulses on completion
//   pkt_start/pkt_pid/  engine command: start pulse, PID, length, payload byte
//   pkt_len/pkt_data
//   pkt_data_ack        engine consumed pkt_data
//   pkt_done            engine finished the packet
//   busy                high whenever the sequencer is not idle
//   err_timeout         1-cycle pulse when the watchdog expires
module usb_tx_sched #(
   parameter int IPG_CYCLES = 8,
   parameter int TO_CYCLES  = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       hs_req,
   input  logic [3:0] hs_pid,
   output logic       hs_done,
   input  logic       dt_req,
   input  logic [3:0] dt_pid,
   input  logic [9:0] dt_len,
   input  logic [7:0] dt_data,
   output logic       dt_data_ack,
   output logic       dt_done,
   output logic       pkt_start,
   output logic [3:0] pkt_pid,
   output logic [9:0] pkt_len,
   output logic [7:0] pkt_data,
   input  logic       pkt_data_ack,
   input  logic       pkt_done,
   output logic       busy,
   output logic       err_timeout
);

   localparam int GAP_W = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
   localparam int WD_W  = (TO_CYCLES  > 0) ? $clog2(TO_CYCLES  + 1) : 1;
   localparam bit WD_EN = (TO_CYCLES > 0);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IPG_CYCLES);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TO_CYCLES);

   typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_HS, OWN_DT} owner_t;

   state_t            state, state_n;
   owner_t            owner, owner_n;
   logic [3:0]        pid_n;
   logic [9:0]        len_n;
   logic [GAP_W-1:0]  gap_cnt, gap_n;
   logic [WD_W-1:0]   wd_cnt, wd_n;
   logic              hs_done_n, dt_done_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= OWN_NONE;
         pkt_pid <= 4'h0;
         pkt_len <= 10'd0;
         gap_cnt <= '0;
         wd_cnt  <= '0;
         hs_done <= 1'b0;
         dt_done <= 1'b0;
      end else begin
         state   <= state_n;
         owner   <= owner_n;
         pkt_pid <= pid_n;
         pkt_len <= len_n;
         gap_cnt <= gap_n;
         wd_cnt  <= wd_n;
         hs_done <= hs_done_n;
         dt_done <= dt_done_n;
      end
   end

   always_comb begin
      state_n     = state;
      owner_n     = owner;
      pid_n       = pkt_pid;
      len_n       = pkt_len;
      gap_n       = gap_cnt;
      wd_n        = wd_cnt;
      hs_done_n   = 1'b0;
      dt_done_n   = 1'b0;
      err_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (tx_en && hs_req) begin
               owner_n = OWN_HS;
               pid_n   = hs_pid;
               len_n   = 10'd0;
               state_n = START;
            end else if (tx_en && dt_req) begin
               owner_n = OWN_DT;
               pid_n   = dt_pid;
               len_n   = dt_len;
               state_n = START;
            end
         end
         START: begin
            // The start cycle itself counts, so wd_cnt equals cycles since pkt_start.
            wd_n    = WD_W'(1);
            state_n = RUN;
         end
         RUN: begin
            if (pkt_done) begin
               // Completion wins over a watchdog expiry in the same cycle.
               hs_done_n = (owner == OWN_HS);
               dt_done_n = (owner == OWN_DT);
               owner_n   = OWN_NONE;
               gap_n     = GAP_LOAD;
               state_n   = GAP;
            end else if (WD_EN && wd_cnt == WD_LIMIT) begin
               err_timeout = 1'b1;
               owner_n     = OWN_NONE;
               gap_n       = GAP_LOAD;
               state_n     = GAP;
            end else if (WD_EN) begin
               wd_n = wd_cnt + WD_W'(1);
            end
         end
         GAP: begin
            // A load of 0 or 1 both leave after a single gap cycle.
            if (gap_cnt <= GAP_W'(1)) state_n = IDLE;
            else                      gap_n   = gap_cnt - GAP_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   // Owner is only DT during START/RUN, so payload and acks never leak outside a DT packet.
   assign pkt_start   = (state == START);
   assign busy        = (state != IDLE);
   assign pkt_data    = (owner == OWN_DT) ? dt_data : 8'h00;
   assign dt_data_ack = (owner == OWN_DT) & pkt_data_ack;

endmodule

// File: tb/tb_usb_tx_sched.sv
module tb_usb_tx_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_en = 1'b0;
   logic       hs_req = 1'b0;
   logic [3:0] hs_pid = 4'h0;
   logic       hs_done;
   logic       dt_req = 1'b0;
   logic [3:0] dt_pid = 4'h0;
   logic [9:0] dt_len = 10'd0;
   logic [7:0] dt_data = 8'h00;
   logic       dt_data_ack, dt_done;
   logic       pkt_start;
   logic [3:0] pkt_pid;
   logic [9:0] pkt_len;
   logic [7:0] pkt_data;
   logic       pkt_data_ack = 1'b0;
   logic       pkt_done = 1'b0;
   logic       busy, err_timeout;

   int vec  = 0;
   int errs = 0;

   usb_tx_sched #(.IPG_CYCLES(8), .TO_CYCLES(20)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en),
      .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
      .dt_req(dt_req), .dt_pid(dt_pid), .dt_len(dt_len), .dt_data(dt_data),
      .dt_data_ack(dt_data_ack), .dt_done(dt_done),
      .pkt_start(pkt_start), .pkt_pid(pkt_pid), .pkt_len(pkt_len), .pkt_data(pkt_data),
      .pkt_data_ack(pkt_data_ack), .pkt_done(pkt_done),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 60) begin
         step();
         n++;
      end
      chk(tag, busy, 0);
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_start", pkt_start, 0);
      chk("rst_pid", pkt_pid, 0);
      chk("rst_len", pkt_len, 0);
      chk("rst_dones", {hs_done, dt_done, dt_data_ack, err_timeout}, 0);
      step(); step();
      rst = 1'b0;
      step();

      // tx_en low blocks grants
      hs_req = 1'b1; hs_pid = 4'h2;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("txen_block", {pkt_start, busy}, 0);
      end

      // HS ACK: grant at N, start at N+1, done M -> hs_done M+1, next grant at M+9
      tx_en = 1'b1;                                   // cycle N
      step();                                         // N+1
      chk("hs_start", pkt_start, 1);
      chk("hs_pid", pkt_pid, 4'h2);
      chk("hs_len", pkt_len, 0);
      chk("hs_busy", busy, 1);
      dt_data = 8'h5A; pkt_data_ack = 1'b1; #1;
      chk("hs_ack_ignored", {dt_data_ack, pkt_data}, 0);
      step();                                         // N+2 = M
      chk("hs_start_1cyc", pkt_start, 0);
      pkt_data_ack = 1'b0; pkt_done = 1'b1; #1;
      chk("hs_done_early", hs_done, 0);
      step();                                         // M+1
      pkt_done = 1'b0;
      chk("hs_done", {hs_done, dt_done, busy}, 3'b101);
      for (int k = 2; k <= 8; k++) begin
         step();
         chk("gap_hold", {pkt_start, busy, hs_done}, 3'b010);
      end
      step();                                         // M+9
      chk("gap_end_idle", {pkt_start, busy}, 0);
      step();                                         // M+10
      chk("regrant_start", pkt_start, 1);
      hs_req = 1'b0; pkt_done = 1'b1;                 // pkt_done in START is ignored
      step();                                         // M+11
      pkt_done = 1'b0;
      chk("done_in_start_ignored", {hs_done, busy}, 2'b01);
      step();
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0;
      chk("hs_done2", hs_done, 1);
      wait_idle("idle_1");

      // DT DATA1, 3 bytes
      dt_req = 1'b1; dt_pid = 4'hB; dt_len = 10'd3; dt_data = 8'h11;
      step();
      chk("dt_start", {pkt_start, pkt_pid, pkt_len}, {1'b1, 4'hB, 10'd3});
      chk("dt_data0", pkt_data, 8'h11);
      step();
      pkt_data_ack = 1'b1; #1;
      chk("dt_ack0", {dt_data_ack, pkt_data}, {1'b1, 8'h11});
      step();
      pkt_data_ack = 1'b0; dt_data = 8'h22; #1;
      chk("dt_noack", {dt_data_ack, pkt_data}, {1'b0, 8'h22});
      step();
      pkt_data_ack = 1'b1; #1;
      chk("dt_ack1", {dt_data_ack, pkt_data}, {1'b1, 8'h22});
      step();
      dt_data = 8'h33; #1;
      chk("dt_ack2", {dt_data_ack, pkt_data}, {1'b1, 8'h33});
      step();
      pkt_data_ack = 1'b0; pkt_done = 1'b1; #1;
      chk("dt_ack_end", {dt_data_ack, dt_done}, 0);
      step();
      pkt_done = 1'b0; dt_req = 1'b0;
      chk("dt_done", {dt_done, hs_done}, 2'b10);
      step();
      chk("dt_done_1cyc", {dt_done, hs_done}, 0);
      wait_idle("idle_2");

      // simultaneous requests: HS first, DT after hs_done + gap
      hs_req = 1'b1; hs_pid = 4'hA; dt_req = 1'b1; dt_pid = 4'h3; dt_len = 10'd5;
      step();
      chk("both_hs_first", {pkt_start, pkt_pid, pkt_len}, {1'b1, 4'hA, 10'd0});
      step();
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0; hs_req = 1'b0;
      chk("both_hs_done", {hs_done, dt_done}, 2'b10);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("both_gap", pkt_start, 0);
      end
      step();
      chk("both_dt_start", {pkt_start, pkt_pid, pkt_len}, {1'b1, 4'h3, 10'd5});
      step();
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0; dt_req = 1'b0;
      chk("both_dt_done", {dt_done, hs_done}, 2'b10);
      wait_idle("idle_3");

      // zero-length DT
      dt_req = 1'b1; dt_pid = 4'h3; dt_len = 10'd0;
      step();
      chk("zlp_start", {pkt_start, pkt_len}, {1'b1, 10'd0});
      step();
      pkt_done = 1'b1; #1;
      chk("zlp_noack", dt_data_ack, 0);
      step();
      pkt_done = 1'b0; dt_req = 1'b0;
      chk("zlp_done", dt_done, 1);
      wait_idle("idle_4");

      // watchdog: no pkt_done -> err_timeout at S+20, then pending HS granted
      dt_req = 1'b1; dt_pid = 4'hB; dt_len = 10'd2;
      step();                                         // S
      chk("wd_start", pkt_start, 1);
      step();                                         // S+1
      dt_req = 1'b0; hs_req = 1'b1; hs_pid = 4'hE;
      for (int k = 1; k <= 19; k++) begin
         chk("wd_quiet", {err_timeout, busy}, 2'b01);
         step();
      end                                             // S+20
      chk("wd_expire", {err_timeout, dt_done, hs_done, busy}, 4'b1001);
      step();                                         // S+21
      chk("wd_after", {err_timeout, dt_done, hs_done, busy}, 4'b0001);
      for (int k = 22; k <= 29; k++) step();          // S+29
      chk("wd_busy_fall", busy, 0);
      step();                                         // S+30 = S'
      chk("wd_hs_grant", {pkt_start, pkt_pid}, {1'b1, 4'hE});
      step();
      hs_req = 1'b0;
      for (int k = 2; k <= 20; k++) step();           // S'+20: expiry cycle
      pkt_done = 1'b1; #1;
      chk("wd_done_wins", err_timeout, 0);
      step();
      pkt_done = 1'b0;
      chk("wd_done_wins_pulse", {hs_done, err_timeout}, 2'b10);
      wait_idle("idle_5");

      // reset mid-RUN, re-grant with re-latched length
      dt_req = 1'b1; dt_pid = 4'hB; dt_len = 10'd7; dt_data = 8'h77;
      step();
      step();
      pkt_data_ack = 1'b1; #1;
      chk("rst_pre_ack", dt_data_ack, 1);
      rst = 1'b1; #1;
      chk("rst_mid_outs", {busy, dt_data_ack, pkt_start, dt_done, hs_done, err_timeout}, 0);
      chk("rst_mid_pkt", {pkt_pid, pkt_len, pkt_data}, 0);
      dt_len = 10'd9;
      step(); step();
      rst = 1'b0; pkt_data_ack = 1'b0;
      step();
      chk("rst_regrant", {pkt_start, pkt_len, dt_done}, {1'b1, 10'd9, 1'b0});
      step();
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0; dt_req = 1'b0;
      chk("rst_regrant_done", dt_done, 1);
      wait_idle("idle_6");

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/usb_tx_sched.md
Name: usb_tx_sched

Overview:
- Sequencer and arbiter in front of the USB TX packet engine (the block with `pkt_start`/`pkt_done`/`pkt_pid`/`pkt_len`/`pkt_data`/`pkt_data_ack`).
- Shares that engine between two requesters:
  - handshake requester (HS): PID-only ACK/NAK/STALL responses from the transaction FSM.
  - data requester (DT): DATA0/DATA1 packets streamed from endpoint buffers.
- Enforces a minimum inter-packet gap and a watchdog, and returns per-requester completion.

Parameters:
- `IPG_CYCLES`, 8, idle clk cycles enforced after each `pkt_done` before the next `pkt_start` (0 = none).
- `TO_CYCLES`, 65535, watchdog: max clk cycles from `pkt_start` to `pkt_done`. Width is `clog2(TO_CYCLES+1)`; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `tx_en`  in  1  grants allowed only while 1 (0 during bus reset/suspend)
- `hs_req`  in  1  HS request, level, held until `hs_done`
- `hs_pid`  in  4  HS PID
- `hs_done`  out  1  1-cycle pulse: HS packet finished
- `dt_req`  in  1  DT request, level, held until `dt_done`
- `dt_pid`  in  4  DT PID
- `dt_len`  in  10  DT payload byte count (0..1023)
- `dt_data`  in  8  current DT payload byte
- `dt_data_ack`  out  1  DT byte consumed, present next byte
- `dt_done`  out  1  1-cycle pulse: DT packet finished
- `pkt_start`  out  1  to engine: start packet
- `pkt_pid`  out  4  to engine
- `pkt_len`  out  10  to engine
- `pkt_data`  out  8  to engine
- `pkt_data_ack`  in  1  from engine
- `pkt_done`  in  1  from engine
- `busy`  out  1  1 whenever state != IDLE
- `err_timeout`  out  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset (async) → state IDLE, owner none. All outputs 0: `pkt_start`, `hs_done`, `dt_done`, `dt_data_ack`, `busy`, `err_timeout`. `pkt_pid`/`pkt_len` = 0. Gap and watchdog counters cleared. An in-flight packet is abandoned with no done pulse.
- States: IDLE, START, RUN, GAP.
- IDLE:
  - Arbitration happens only when `tx_en`=1.
  - Fixed priority: HS over DT.
  - On grant, latch owner, and register `pkt_pid` ← `hs_pid` or `dt_pid`, `pkt_len` ← 0 or `dt_len`. Go to START.
  - Both requests in the same cycle → HS wins; DT is served after HS done + gap.
- START:
  - `pkt_start`=1 for exactly one cycle, then RUN.
  - Latency: request seen in IDLE at cycle N → `pkt_start` high in cycle N+1.
- RUN:
  - `pkt_pid`/`pkt_len` held stable.
  - `pkt_data` = `dt_data` combinationally whenever owner=DT, else 0.
  - `dt_data_ack` = `pkt_data_ack` when owner=DT, else 0. A `pkt_data_ack` with owner=HS is ignored.
  - On `pkt_done`: pulse owner's done (registered, cycle after `pkt_done`), go to GAP.
  - Request deassertion during RUN is ignored; the packet completes.
- GAP:
  - Counter loads `IPG_CYCLES` on entry, counts down, returns to IDLE when it reaches 0.
  - `IPG_CYCLES`=0 → GAP lasts 1 cycle.
  - Arbitration resumes only in IDLE, so a requester must drop `req` on its done pulse or it is re-granted.
- Watchdog:
  - Counter starts at `pkt_start`, counts in RUN.
  - On reaching `TO_CYCLES` without `pkt_done`: pulse `err_timeout`, no done pulse, go to GAP.
  - A `pkt_done` in the expiry cycle wins: normal completion, no error.
- `tx_en` falling during START/RUN does not abort; it only blocks new grants.
- A `pkt_done` arriving in IDLE/GAP/START is ignored.

Test Plan:
- `hs_req`=1, `hs_pid`=ACK(0x2) in IDLE at cycle N → `pkt_start` at N+1 with `pkt_pid`=0x2, `pkt_len`=0. `pkt_done` at M → `hs_done` at M+1. With `IPG_CYCLES`=8, next grant no earlier than M+9.
- `dt_req`, `dt_pid`=DATA1(0xB), `dt_len`=3, bytes 0x11,0x22,0x33 → three `dt_data_ack` pulses, each mirroring `pkt_data_ack` exactly; `pkt_data` matches each byte; `dt_done` once; `hs_done` never.
- `hs_req` and `dt_req` rise in the same cycle → HS packet first. DT `pkt_start` comes after `hs_done` + gap, with `pkt_len`=`dt_len`.
- `dt_len`=0 → `pkt_start` with `pkt_len`=0, no `dt_data_ack`, `dt_done` after `pkt_done`.
- `TO_CYCLES`=20, engine never returns `pkt_done` → `err_timeout` pulse 20 cycles after `pkt_start`, no done pulse, `busy` falls after the gap, and a pending `hs_req` is then granted.
- Assert `rst` mid-RUN of a DT packet → all outputs 0 immediately and `busy`=0. After release with `dt_req` still high, a fresh `pkt_start` with the re-latched `dt_len`.
